// File: rtl/terrain_pkg.sv
// terrain_pkg: shared terrain geometry, column word type and carver FSM states.
package terrain_pkg;

  localparam int TERR_W = 640;
  localparam int TERR_H = 480;
  localparam int R_MAX  = 63;

  typedef logic [TERR_H-1:0] terrain_col_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FIT   = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } carver_state_t;

  // Square of a 7-bit magnitude; zero-extended so the product keeps all 14 bits.
  function automatic logic [13:0] sq7(input logic [6:0] v);
    return {7'd0, v} * {7'd0, v};
  endfunction

endpackage

// File: rtl/carve_mask_gen.sv
// carve_mask_gen: column mask with bits y-h..y+h set, clipped to the terrain rows.
module carve_mask_gen
  import terrain_pkg::*;
(
  input  logic [9:0]   y,
  input  logic [5:0]   h,
  output terrain_col_t mask
);

  logic signed [11:0] lo;
  logic signed [11:0] hi;

  assign lo = $signed({2'b00, y}) - $signed({6'd0, h});
  assign hi = $signed({2'b00, y}) + $signed({6'd0, h});

  // Rows outside 0..TERR_H-1 simply have no bit, so clipping falls out of the range test.
  always_comb begin
    mask = '0;
    for (int i = 0; i < TERR_H; i++) begin
      mask[i] = ($signed(12'(i)) >= lo) && ($signed(12'(i)) <= hi);
    end
  end

endmodule

// File: rtl/terrain_carver.sv
// terrain_carver: removes a filled disc from the column-organised terrain bitmap,
// one read-modify-write per column through an arbitrated single-port RAM.
module terrain_carver
  import terrain_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [9:0]        req_y,
  input  logic [6:0]        req_r,
  output logic              busy,
  output logic              done,
  input  logic              mem_gnt,
  output logic              mem_req,
  output logic [9:0]        mem_addr,
  output logic              mem_rd,
  input  logic [TERR_H-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [TERR_H-1:0] mem_wdata
);

  localparam logic [9:0] X_LIM   = 10'(TERR_W);
  localparam logic [9:0] Y_LIM   = 10'(TERR_H);
  localparam logic [9:0] X_LAST  = 10'(TERR_W - 1);
  localparam logic [6:0] R_LIM   = 7'(R_MAX);
  localparam logic [5:0] R_CLAMP = 6'(R_MAX);

  carver_state_t state;
  carver_state_t state_nxt;

  logic [9:0]   cen_x;
  logic [9:0]   cen_y;
  logic [9:0]   cx;
  logic [9:0]   cx_end;
  logic [5:0]   rad;
  logic [5:0]   h;
  terrain_col_t col_buf;
  terrain_col_t mask;

  logic [5:0]   r_clamp;
  logic [9:0]   start_cx;
  logic [10:0]  end_sum;
  logic [9:0]   end_cx;
  logic         in_range;

  assign r_clamp  = (req_r > R_LIM) ? R_CLAMP : req_r[5:0];
  assign start_cx = (req_x > {4'd0, r_clamp}) ? (req_x - {4'd0, r_clamp}) : 10'd0;
  assign end_sum  = {1'b0, req_x} + {5'd0, r_clamp};
  assign end_cx   = (end_sum > {1'b0, X_LAST}) ? X_LAST : end_sum[9:0];
  assign in_range = (req_x < X_LIM) && (req_y < Y_LIM);

  // Half-height search: h walks one step per cycle toward floor(sqrt(r^2 - dx^2)).
  logic [6:0]  dx_mag;
  logic [6:0]  h_ext;
  logic [6:0]  h_inc;
  logic [13:0] dx_sq;
  logic [13:0] h_sq;
  logic [13:0] h_inc_sq;
  logic [13:0] r_sq;
  logic        grow;
  logic        shrink;

  assign dx_mag   = (cx >= cen_x) ? 7'(cx - cen_x) : 7'(cen_x - cx);
  assign h_ext    = {1'b0, h};
  assign h_inc    = h_ext + 7'd1;
  assign dx_sq    = sq7(dx_mag);
  assign h_sq     = sq7(h_ext);
  assign h_inc_sq = sq7(h_inc);
  assign r_sq     = sq7({1'b0, rad});
  assign grow     = ({1'b0, h_inc_sq} + {1'b0, dx_sq}) <= {1'b0, r_sq};
  assign shrink   = ({1'b0, h_sq} + {1'b0, dx_sq}) > {1'b0, r_sq};

  carve_mask_gen u_mask (
    .y    (cen_y),
    .h    (h),
    .mask (mask)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request latch, column walker, half-height and read-data capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cen_x   <= 10'd0;
      cen_y   <= 10'd0;
      rad     <= 6'd0;
      cx      <= 10'd0;
      cx_end  <= 10'd0;
      h       <= 6'd0;
      col_buf <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cen_x  <= req_x;
            cen_y  <= req_y;
            rad    <= r_clamp;
            cx     <= start_cx;
            cx_end <= end_cx;
            h      <= 6'd0;
          end
        end
        ST_FIT: begin
          if (grow) begin
            h <= h + 6'd1;
          end else if (shrink) begin
            h <= h - 6'd1;
          end
        end
        ST_WAIT: col_buf <= mem_rdata;
        ST_NEXT: begin
          if (cx != cx_end) begin
            cx <= cx + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and RAM handshake; strobes follow the grant in the same cycle.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = in_range ? ST_FIT : ST_DONE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_FIT: begin
        if (grow || shrink) begin
          state_nxt = ST_FIT;
        end else begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        mem_req   = 1'b1;
        mem_rd    = mem_gnt;
        state_nxt = mem_gnt ? ST_WAIT : ST_READ;
      end
      ST_WAIT: state_nxt = ST_WRITE;
      ST_WRITE: begin
        mem_req   = 1'b1;
        mem_wr    = mem_gnt;
        mem_wdata = col_buf & ~mask;
        state_nxt = mem_gnt ? ST_NEXT : ST_WRITE;
      end
      ST_NEXT: state_nxt = (cx == cx_end) ? ST_DONE : ST_FIT;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_addr  = cx;
  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_terrain_carver.sv
// tb_terrain_carver: scoreboard bench with a column RAM model and directed crater requests.
module tb_terrain_carver;

  localparam int W = 640;
  localparam int H = 480;
  typedef logic [H-1:0] col_t;
  typedef struct packed {
    logic       is_done;
    logic [9:0] addr;
    col_t       data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_x;
  logic [9:0] req_y;
  logic [6:0] req_r;
  logic       busy;
  logic       done;
  logic       mem_gnt;
  logic       mem_req;
  logic [9:0] mem_addr;
  logic       mem_rd;
  col_t       mem_rdata;
  logic       mem_wr;
  col_t       mem_wdata;

  col_t ram    [0:W-1];
  col_t shadow [0:W-1];
  col_t img1   [0:W-1];
  logic ram_fill = 1'b0;
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;

  always #5 clk = ~clk;

  terrain_carver dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_r     (req_r),
    .busy      (busy),
    .done      (done),
    .mem_gnt   (mem_gnt),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata)
  );

  // Single-port RAM: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int c = 0; c < W; c++) ram[c] <= '1;
    end else begin
      if (mem_rd) mem_rdata <= ram[mem_addr];
      if (mem_wr) ram[mem_addr] <= mem_wdata;
    end
  end

  // Monitor: every write and every done pulse is matched against the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (mem_rd || mem_wr) begin
        checks++;
        if (mem_rd && mem_wr) begin
          errors++;
          $display("FAIL rd_wr_overlap act=both exp=one");
        end
      end
      if (mem_wr) begin
        wr_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d", mem_addr);
        end else begin
          e = exp_q.pop_front();
          if (e.is_done || e.addr != mem_addr || e.data !== mem_wdata) begin
            errors++;
            $display("FAIL wr_txn addr act=%0d exp=%0d done_exp=%0b data act=%h exp=%h",
                     mem_addr, e.addr, e.is_done, mem_wdata, e.data);
          end
        end
      end
      if (done) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done act=1 exp=0");
        end else begin
          e = exp_q.pop_front();
          if (!e.is_done) begin
            errors++;
            $display("FAIL done_order act=done exp=write addr %0d", e.addr);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [H-1:0] act, input logic [H-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fill_all();
    @(posedge clk); #1 ram_fill = 1'b1;
    @(posedge clk); #1 ram_fill = 1'b0;
    for (int c = 0; c < W; c++) shadow[c] = '1;
  endtask

  // Reference: per column, the largest h with h^2+dx^2 <= r^2, found by search.
  task automatic push_carve(input int x, input int y, input int r);
    int   rr, lo, hi, dx, h;
    col_t col;
    exp_t e;
    rr = (r > 63) ? 63 : r;
    if (x < W && y < H) begin
      lo = (x - rr < 0) ? 0 : x - rr;
      hi = (x + rr > W - 1) ? W - 1 : x + rr;
      for (int c = lo; c <= hi; c++) begin
        dx = c - x;
        h = 0;
        while ((h + 1) * (h + 1) + dx * dx <= rr * rr) h++;
        col = shadow[c];
        for (int i = y - h; i <= y + h; i++) if (i >= 0 && i < H) col[i] = 1'b0;
        shadow[c] = col;
        e.is_done = 1'b0;
        e.addr = 10'(c);
        e.data = col;
        exp_q.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.addr = 10'd0;
    e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int x, input int y, input int r);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_x = 10'(x);
    req_y = 10'(y);
    req_r = 7'(r);
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk("done_seen", seen, 1'b1);
    @(negedge clk);
    chk("done_pulse_width", done, 1'b0);
  endtask

  task automatic cmp_shadow(input string name);
    int d = 0;
    for (int c = 0; c < W; c++) if (ram[c] !== shadow[c]) d++;
    chk(name, d, 0);
  endtask

  initial begin
    col_t e97;
    int   n, d, wr0;
    e97 = '1;
    e97[200] = 1'b0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_x = 10'd0;
    req_y = 10'd0;
    req_r = 7'd0;
    mem_gnt = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    fill_all();
    @(posedge clk); #1 reset = 1'b1;

    // 1: basic r=3 crater
    push_carve(100, 200, 3);
    issue(100, 200, 3);
    wait_done(300);
    chk("t1_col100_hole", ram[100][203:197], 0);
    chk("t1_col100_above", ram[100][196], 1'b1);
    chk("t1_col100_below", ram[100][204], 1'b1);
    chk("t1_col98_hole", ram[98][202:198], 0);
    chk("t1_col98_edge", {ram[98][203], ram[98][197]}, 2'b11);
    chk("t1_col97", ram[97], e97);
    chk("t1_col103", ram[103], e97);
    chk("t1_col96", ram[96], {H{1'b1}});
    chk("t1_col104", ram[104], {H{1'b1}});
    cmp_shadow("t1_image");
    for (int c = 0; c < W; c++) img1[c] = ram[c];

    // 2: left clip
    fill_all();
    push_carve(2, 10, 5);
    issue(2, 10, 5);
    wait_done(300);
    chk("t2_col0_hole", ram[0][14:6], 0);
    chk("t2_col0_edge", {ram[0][15], ram[0][5]}, 2'b11);
    chk("t2_col639", ram[639], {H{1'b1}});
    chk("t2_col8", ram[8], {H{1'b1}});
    cmp_shadow("t2_image");

    // 3: bottom clip
    fill_all();
    push_carve(300, 478, 4);
    issue(300, 478, 4);
    wait_done(300);
    chk("t3_col300_hole", ram[300][479:474], 0);
    chk("t3_col300_edge", ram[300][473], 1'b1);
    chk("t3_col300_top", ram[300][3:0], 4'hF);
    cmp_shadow("t3_image");

    // 4: grant withheld during READ, then during WRITE
    fill_all();
    push_carve(100, 200, 3);
    mem_gnt = 1'b0;
    issue(100, 200, 3);
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t4_req_seen", mem_req, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("t4_rd_stall", {mem_req, mem_rd, mem_wr}, 3'b100);
      chk("t4_rd_addr", mem_addr, 97);
    end
    @(posedge clk); #1 mem_gnt = 1'b1;
    @(posedge clk); #1 mem_gnt = 1'b0;
    @(posedge clk);
    repeat (10) begin
      @(negedge clk);
      chk("t4_wr_stall", {mem_req, mem_rd, mem_wr}, 3'b100);
      chk("t4_wr_addr", mem_addr, 97);
      chk("t4_wr_data", mem_wdata, e97);
    end
    @(posedge clk); #1 mem_gnt = 1'b1;
    wait_done(300);
    d = 0;
    for (int c = 0; c < W; c++) if (ram[c] !== img1[c]) d++;
    chk("t4_same_as_t1", d, 0);

    // 5: request held while busy, clamp, out-of-range
    fill_all();
    push_carve(100, 200, 3);
    push_carve(50, 100, 100);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_x = 10'd100;
    req_y = 10'd200;
    req_r = 7'd3;
    @(posedge clk); #1;
    req_x = 10'd50;
    req_y = 10'd100;
    req_r = 7'd100;
    repeat (3) begin
      @(negedge clk);
      chk("t5_ready_busy", {req_ready, busy}, 2'b01);
    end
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t5_first_done", done, 1'b1);
    @(negedge clk);
    chk("t5_ready_after_done", {req_ready, busy}, 2'b10);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("t5_second_accepted", busy, 1'b1);
    wait_done(3000);
    chk("t5_col50_hole", ram[50][163:37], 0);
    chk("t5_col50_edge", {ram[50][164], ram[50][36]}, 2'b11);
    chk("t5_col113_row", {ram[113][101], ram[113][100], ram[113][99]}, 3'b101);
    chk("t5_col114", ram[114], {H{1'b1}});
    cmp_shadow("t5_image");
    wr0 = wr_count;
    push_carve(700, 5, 3);
    issue(700, 5, 3);
    wait_done(20);
    push_carve(10, 480, 2);
    issue(10, 480, 2);
    wait_done(20);
    chk("t5_oob_no_writes", wr_count - wr0, 0);

    // 6: reset asserted mid-WRITE
    fill_all();
    push_carve(100, 200, 3);
    issue(100, 200, 3);
    n = 0;
    while (!(mem_wr && mem_addr == 10'd99) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("t6_third_write_seen", {mem_wr, mem_addr}, {1'b1, 10'd99});
    #1 reset = 1'b0;
    #1;
    chk("t6_abort", {mem_wr, busy, mem_req}, 3'b000);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", {req_ready, busy}, 2'b10);
    repeat (5) @(negedge clk);
    chk("t6_col97_kept", ram[97], e97);
    chk("t6_col98_kept", ram[98][202:198], 0);
    chk("t6_col99_unwritten", ram[99], {H{1'b1}});
    chk("t6_col100_unwritten", ram[100], {H{1'b1}});

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
